stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, meaning debounce window in ms; DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, minimum 1.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_start_stop  input  1  raw push-button, asynchronous to clk, active-high.
REQ-006 SHALL have port btn_clear  input  1  raw push-button, asynchronous to clk, active-high.
REQ-007 SHALL have port btn_lap  input  1  raw push-button, asynchronous to clk, active-high.
REQ-008 SHALL have port time_reading  input  8  BCD {tens,ones} seconds from downstream counter.
REQ-009 SHALL have port init_regs  output  1  synchronous clear request to counter.
REQ-010 SHALL have port count_enabled  output  1  counting enable to counter.
REQ-011 SHALL have port display_reading  output  8  BCD value for display: live or frozen lap.
REQ-012 SHALL have port lap_active  output  1  high while display_reading is frozen.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Each synchronized button SHALL have a debounced level that changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-015 A one-cycle press pulse SHALL be generated on each 0->1 transition of a debounced level; release generates nothing; holding generates exactly one pulse.
REQ-016 Latency from a clean raw rising edge to press pulse SHALL be 2 + DB_CYCLES + 1 cycles, constant.
REQ-017 Control FSM SHALL have states IDLE, RUN, PAUSE, state-encoded, registered.
REQ-018 Transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSE; PAUSE+start_stop->RUN; PAUSE+clear->IDLE; IDLE+clear->IDLE; RUN+clear ignored (stay RUN).
REQ-019 Simultaneous pulses in one cycle SHALL be prioritized clear > start_stop > lap; lower-priority pulses in that cycle are discarded.
REQ-020 init_regs SHALL be 1 iff state==IDLE; count_enabled SHALL be 1 iff state==RUN; both decoded from the state register only (glitch-free, Moore).
REQ-021 Output effect of a press pulse in cycle N SHALL appear at cycle N+1.
REQ-022 lap pulse in RUN SHALL toggle lap_active; lap pulse in PAUSE or IDLE SHALL clear lap_active if set, else be ignored.
REQ-023 Any transition to IDLE SHALL clear lap_active in the same edge.
REQ-024 display_reading SHALL be a register loading time_reading every cycle while lap_active==0 (1-cycle latency) and holding while lap_active==1; on the edge setting lap_active it SHALL load time_reading of that cycle.
REQ-025 time_reading SHALL be passed through unmodified, with no BCD validity check.

Reset
REQ-026 reset SHALL asynchronously force state=IDLE, lap_active=0, display_reading=8'h00, all synchronizer, debounce and edge registers to 0, all debounce counters to 0.
REQ-027 While reset is high: init_regs=1, count_enabled=0; after release no press pulse SHALL occur unless a button is pressed after release.

Verification (sim with CLK_FREQ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4)
REQ-028 Reset then idle 20 cycles -> init_regs=1, count_enabled=0, display_reading=00, lap_active=0.
REQ-029 btn_start_stop high 10 cycles with 3 one-cycle bounces at start -> single pulse, count_enabled=1 seven cycles after the last bounce; second press -> count_enabled=0, init_regs=0 (PAUSE).
REQ-030 In RUN, time_reading=8'h23 then lap press, then time_reading steps to 8'h27 -> display_reading holds 23, lap_active=1; second lap press -> display follows 27 one cycle later.
REQ-031 In RUN press clear -> no state change; in PAUSE press clear -> init_regs=1, lap_active=0.
REQ-032 start_stop and clear debounce-complete in the same cycle while in PAUSE -> state IDLE, not RUN.
REQ-033 Assert reset mid-debounce and in RUN with lap_active=1 -> immediate IDLE, lap_active=0, display 00; button still held after release produces no pulse until released and re-pressed.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Purpose  : Button, time and display signals between the stopwatch
//            controller and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [7:0] time_reading;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] display_reading;
  logic       lap_active;

  // Environment side: drives the raw buttons and the counter value.
  modport master (
    output btn_start_stop, btn_clear, btn_lap, time_reading,
    input  init_regs, count_enabled, display_reading, lap_active
  );

  // Controller side.
  modport slave (
    input  btn_start_stop, btn_clear, btn_lap, time_reading,
    output init_regs, count_enabled, display_reading, lap_active
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Stopwatch control. Synchronizes and debounces three push-buttons
//            into single press pulses and runs the IDLE/RUN/PAUSE machine
//            that drives the counter enable/clear and a lap-freezable display.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int DB_RAW    = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Button order in all vectors: [0]=start_stop, [1]=clear, [2]=lap.
  logic [2:0] raw_btn;
  assign raw_btn = {bus.btn_lap, bus.btn_clear, bus.btn_start_stop};

  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [1:0] sync_ok_q, sync_ok_d;   // [1] set once stage 2 holds real samples
  logic [2:0] press;

  // Two-flop synchronizer next values and the post-reset sample-valid shifter.
  always_comb begin
    sync1_d   = raw_btn;
    sync2_d   = sync1_q;
    sync_ok_d = {sync_ok_q[0], 1'b1};
  end

  // Synchronizer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync_ok_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync_ok_q <= sync_ok_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic level_q, level_d;
      logic prev_q, prev_d;
      logic armed_q, armed_d;
      logic pulse_q, pulse_d;

      // Debounce: level follows the input only after DB_CYCLES straight
      // mismatching samples. A press is only accepted once the button has
      // been seen released after reset, so a button held through reset
      // stays silent until it is let go and pressed again.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q[gi] != level_q) begin
          if (cnt_q == CNT_LAST) begin
            level_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        prev_d  = level_q;
        armed_d = armed_q | (sync_ok_q[1] & ~sync2_q[gi]);
        pulse_d = level_q & ~prev_q & armed_q;
      end

      // Debounce, edge-detect and arming registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
          prev_q  <= 1'b0;
          armed_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
          prev_q  <= prev_d;
          armed_q <= armed_d;
          pulse_q <= pulse_d;
        end
      end

      assign press[gi] = pulse_q;
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       lap_q, lap_d;
  logic [7:0] disp_q, disp_d;
  logic       init_q, init_d;
  logic       cen_q, cen_d;
  logic       go_clr, go_ss, go_lap;

  // Control decisions: clear beats start_stop beats lap; losers are dropped.
  always_comb begin
    go_clr  = press[1];
    go_ss   = press[0] & ~press[1];
    go_lap  = press[2] & ~press[1] & ~press[0];
    state_d = state_q;
    lap_d   = lap_q;
    case (state_q)
      ST_IDLE: begin
        if (go_ss) begin
          state_d = ST_RUN;
        end else if (go_lap) begin
          lap_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (go_ss) begin
          state_d = ST_PAUSE;
        end else if (go_lap) begin
          lap_d = ~lap_q;
        end
      end
      ST_PAUSE: begin
        if (go_clr) begin
          state_d = ST_IDLE;
        end else if (go_ss) begin
          state_d = ST_RUN;
        end else if (go_lap) begin
          lap_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      lap_d = 1'b0;
    end
    // Loads on the edge that sets lap_active too, since lap_q is still 0.
    disp_d = lap_q ? disp_q : bus.time_reading;
    init_d = (state_d == ST_IDLE);
    cen_d  = (state_d == ST_RUN);
  end

  // State and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lap_q   <= 1'b0;
      disp_q  <= 8'h00;
      init_q  <= 1'b1;
      cen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      disp_q  <= disp_d;
      init_q  <= init_d;
      cen_q   <= cen_d;
    end
  end

  assign bus.init_regs       = init_q;
  assign bus.count_enabled   = cen_q;
  assign bus.display_reading = disp_q;
  assign bus.lap_active      = lap_q;

endmodule
`default_nettype wire
